// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, types and helpers for the seven-segment scan path
package seg_pkg;

    localparam int NUM_DIGITS = 6;

    // Active-high g..a patterns for 0-F; the scan bus carries the complement.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] BLANK_RAW = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } cap_state_e;

    function automatic logic sel_legal(input logic [NUM_DIGITS-1:0] sel_n);
        int unsigned lows;
        lows = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!sel_n[i]) lows++;
        end
        return lows == 1;
    endfunction

    function automatic logic [2:0] sel_index(input logic [NUM_DIGITS-1:0] sel_n);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!sel_n[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_pattern_decoder.sv
// rtl/seg_pattern_decoder.sv - active-high 7-segment pattern back to a hex value
module seg_pattern_decoder
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] value
);

    always_comb begin
        hit   = 1'b0;
        value = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (seg == HEX_SEG[i]) begin
                hit   = 1'b1;
                value = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - scan bus monitor assembling captured digits into published frames
module seg_capture
    import seg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int STABLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  seg_sel,
    input  logic [7:0]  seg_data,
    input  logic        clr,
    output logic [23:0] digits,
    output logic [5:0]  dp,
    output logic [5:0]  blank,
    output logic [5:0]  err,
    output logic        frame_done,
    output logic        valid
);

    localparam logic [7:0]  SETTLE_N  = 8'(SETTLE_CYCLES);
    localparam logic [3:0]  STABLE_N  = 4'(STABLE_FRAMES);
    localparam logic [23:0] TIMEOUT_N = 24'(TIMEOUT_CYCLES);

    logic [5:0]  sel_q;
    logic [7:0]  data_q;

    cap_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  cur_sel_q, cur_sel_d;

    logic        sel_ok, sel_changed, capture;
    logic [7:0]  cnt_inc;
    logic [2:0]  idx;
    logic        dec_hit;
    logic [3:0]  dec_val;
    logic        cap_blank, cap_err;
    logic [3:0]  cap_val;

    logic [23:0] sh_digits_q, sh_digits_d;
    logic [5:0]  sh_dp_q, sh_dp_d, sh_blank_q, sh_blank_d, sh_err_q, sh_err_d;
    logic [5:0]  seen_q, seen_d;
    logic [23:0] digits_q, digits_d;
    logic [5:0]  dp_q, dp_d, blank_q, blank_d, err_q, err_d;
    logic        frame_done_q, frame_done_d, valid_q, valid_d;
    logic [3:0]  stable_q, stable_d;
    logic [23:0] tmr_q, tmr_d;
    logic        publish, same;

    // Pins are registered once; everything downstream sees only these copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= '1;
            data_q <= '1;
        end else begin
            sel_q  <= seg_sel;
            data_q <= seg_data;
        end
    end

    assign sel_ok      = sel_legal(sel_q);
    assign sel_changed = (sel_q != cur_sel_q);
    assign cnt_inc     = cnt_q + 8'd1;
    assign idx         = sel_index(sel_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            cur_sel_q <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_sel_q <= cur_sel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_sel_d = cur_sel_q;
        if (clr) begin
            state_d   = ST_IDLE;
            cnt_d     = 8'd0;
            cur_sel_d = '1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = 8'd0;
                    if (sel_ok) begin
                        state_d   = ST_SETTLE;
                        cur_sel_d = sel_q;
                    end
                end
                ST_SETTLE, ST_HOLD: begin
                    if (sel_changed) begin
                        cnt_d     = 8'd0;
                        cur_sel_d = sel_q;
                        state_d   = sel_ok ? ST_SETTLE : ST_IDLE;
                    end else if (state_q == ST_SETTLE) begin
                        if (capture) begin
                            state_d = ST_HOLD;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        capture = (state_q == ST_SETTLE) && !sel_changed && (cnt_inc == SETTLE_N);
    end

    seg_pattern_decoder u_dec (
        .seg   (~data_q[6:0]),
        .hit   (dec_hit),
        .value (dec_val)
    );

    assign cap_blank = (data_q[6:0] == BLANK_RAW);
    assign cap_err   = !dec_hit && !cap_blank;
    assign cap_val   = dec_hit ? dec_val : 4'd0;

    always_comb begin
        sh_digits_d  = sh_digits_q;
        sh_dp_d      = sh_dp_q;
        sh_blank_d   = sh_blank_q;
        sh_err_d     = sh_err_q;
        seen_d       = seen_q;
        digits_d     = digits_q;
        dp_d         = dp_q;
        blank_d      = blank_q;
        err_d        = err_q;
        frame_done_d = 1'b0;
        stable_d     = stable_q;
        tmr_d        = tmr_q;
        valid_d      = 1'b0;
        publish      = 1'b0;
        same         = 1'b0;

        if (capture) begin
            sh_digits_d[{idx, 2'b00} +: 4] = cap_val;
            sh_dp_d[idx]    = ~data_q[7];
            sh_blank_d[idx] = cap_blank;
            sh_err_d[idx]   = cap_err;
            seen_d[idx]     = 1'b1;
        end

        // The sixth capture publishes on the same edge, so a publish always beats expiry.
        publish = (seen_d == '1);
        same    = ({sh_digits_d, sh_dp_d, sh_blank_d, sh_err_d} ==
                   {digits_q, dp_q, blank_q, err_q});
        if (publish) begin
            digits_d     = sh_digits_d;
            dp_d         = sh_dp_d;
            blank_d      = sh_blank_d;
            err_d        = sh_err_d;
            frame_done_d = 1'b1;
            seen_d       = '0;
            tmr_d        = 24'd0;
            if (!same)                stable_d = 4'd1;
            else if (stable_q != 4'hF) stable_d = stable_q + 4'd1;
        end else begin
            if (tmr_q != TIMEOUT_N) tmr_d = tmr_q + 24'd1;
            if (tmr_d == TIMEOUT_N) stable_d = 4'd0;
        end
        valid_d = (stable_d >= STABLE_N) && (tmr_d != TIMEOUT_N);

        if (clr) begin
            sh_digits_d  = '0;
            sh_dp_d      = '0;
            sh_blank_d   = '0;
            sh_err_d     = '0;
            seen_d       = '0;
            digits_d     = '0;
            dp_d         = '0;
            blank_d      = '0;
            err_d        = '0;
            frame_done_d = 1'b0;
            stable_d     = 4'd0;
            tmr_d        = 24'd0;
            valid_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digits_q  <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '0;
            sh_err_q     <= '0;
            seen_q       <= '0;
            digits_q     <= '0;
            dp_q         <= '0;
            blank_q      <= '0;
            err_q        <= '0;
            frame_done_q <= 1'b0;
            valid_q      <= 1'b0;
            stable_q     <= 4'd0;
            tmr_q        <= 24'd0;
        end else begin
            sh_digits_q  <= sh_digits_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            sh_err_q     <= sh_err_d;
            seen_q       <= seen_d;
            digits_q     <= digits_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
            valid_q      <= valid_d;
            stable_q     <= stable_d;
            tmr_q        <= tmr_d;
        end
    end

    assign digits     = digits_q;
    assign dp         = dp_q;
    assign blank      = blank_q;
    assign err        = err_q;
    assign frame_done = frame_done_q;
    assign valid      = valid_q;

endmodule

// File: tb/tb_seg_capture.sv
// tb/tb_seg_capture.sv - directed and randomized checks of seg_capture against a frame-level model
module tb_seg_capture;
    import seg_pkg::*;

    localparam int S  = 4;
    localparam int SF = 2;
    localparam int T  = 50;
    localparam logic [6:0] TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  seg_sel;
    logic [7:0]  seg_data;
    logic        clr;
    logic [23:0] digits;
    logic [5:0]  dp, blank, err;
    logic        frame_done, valid;

    seg_capture #(.SETTLE_CYCLES(S), .STABLE_FRAMES(SF), .TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_sel    (seg_sel),
        .seg_data   (seg_data),
        .clr        (clr),
        .digits     (digits),
        .dp         (dp),
        .blank      (blank),
        .err        (err),
        .frame_done (frame_done),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cycle_no = 0, fd_count = 0, m_last_fd = 0;

    // Reference model: per-digit records for shadow and published frame.
    int   sv [6], pv [6];
    bit   sdp[6], sbl[6], ser[6], pdp[6], pbl[6], per[6], mseen[6];
    int   mstable, mtmr, run, pend_idx;
    bit   mfd, mvalid, pend;
    logic [5:0] prev_sel;
    logic [7:0] pend_data;

    function automatic logic [7:0] enc(input int v, input bit lit_dp);
        logic [6:0] p;
        p = TBL[v];
        return {~lit_dp, ~p};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 6; k++) begin
            sv[k] = 0; pv[k] = 0; sdp[k] = 0; sbl[k] = 0; ser[k] = 0;
            pdp[k] = 0; pbl[k] = 0; per[k] = 0; mseen[k] = 0;
        end
        mstable = 0; mtmr = 0; mfd = 0; mvalid = 0; pend = 0;
    endtask

    task automatic model_edge(input logic [5:0] s, input logic [7:0] d, input logic c);
        logic [6:0] lit;
        bit all_seen, same;
        if (c) begin
            model_reset();
        end else begin
            if (pend) begin
                lit = ~pend_data[6:0];
                sdp[pend_idx] = !pend_data[7];
                sbl[pend_idx] = (lit == 7'h00);
                ser[pend_idx] = (lit != 7'h00);
                sv[pend_idx]  = 0;
                for (int k = 0; k < 16; k++)
                    if (TBL[k] == lit) begin sv[pend_idx] = k; ser[pend_idx] = 0; end
                mseen[pend_idx] = 1;
            end
            all_seen = 1;
            for (int k = 0; k < 6; k++) if (!mseen[k]) all_seen = 0;
            mfd = 0;
            if (all_seen) begin
                same = 1;
                for (int k = 0; k < 6; k++) begin
                    if (sv[k] != pv[k] || sdp[k] != pdp[k] || sbl[k] != pbl[k] || ser[k] != per[k]) same = 0;
                    pv[k] = sv[k]; pdp[k] = sdp[k]; pbl[k] = sbl[k]; per[k] = ser[k]; mseen[k] = 0;
                end
                mstable = same ? ((mstable < 15) ? mstable + 1 : 15) : 1;
                mtmr = 0;
                mfd = 1;
                m_last_fd = cycle_no + 1;
            end else begin
                if (mtmr < T) mtmr++;
                if (mtmr == T) mstable = 0;
            end
            mvalid = (mstable >= SF) && (mtmr < T);
        end
        // A digit is taken from the pin sample that completes S+1 cycles of one legal select.
        if (c || s != prev_sel) run = 1;
        else if (run < 1000) run++;
        prev_sel = s;
        pend = ($countones(~s) == 1) && (run == S + 1);
        pend_data = d;
        pend_idx = 0;
        for (int k = 0; k < 6; k++) if (!s[k]) pend_idx = k;
    endtask

    function automatic logic [43:0] exp_bus();
        logic [23:0] dg;
        logic [5:0] a, b, e;
        for (int k = 0; k < 6; k++) begin
            dg[4*k +: 4] = 4'(pv[k]);
            a[k] = pdp[k]; b[k] = pbl[k]; e[k] = per[k];
        end
        return {dg, a, b, e, mfd, mvalid};
    endfunction

    task automatic chk(input string tag, input logic [43:0] obs, input logic [43:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [5:0] s, input logic [7:0] d, input logic c);
        seg_sel = s; seg_data = d; clr = c;
        @(posedge clk); #1;
        model_edge(s, d, c);
        cycle_no++;
        if (frame_done) fd_count++;
        chk($sformatf("cycle%0d_outputs", cycle_no),
            {digits, dp, blank, err, frame_done, valid}, exp_bus());
    endtask

    task automatic scan_digit(input int i, input logic [7:0] d, input int len);
        logic [5:0] s;
        s = ~(6'(1) << i);
        for (int k = 0; k < len; k++) cyc(s, d, 1'b0);
    endtask

    task automatic scan_frame(input logic [23:0] vals, input int len);
        for (int i = 0; i < 6; i++) scan_digit(i, enc(int'(vals[4*i +: 4]), 1'b0), len);
    endtask

    initial begin
        int fd0;
        bit saw49, saw50;
        logic [5:0] rs;
        logic [7:0] rd;
        int rl;
        logic rc;

        rst_n = 1'b0; clr = 1'b0; seg_sel = '1; seg_data = '1;
        model_reset(); prev_sel = '1; run = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {digits, dp, blank, err, frame_done, valid}, 44'd0);
        chk("reset_seen", 44'(dut.seen_q), 44'd0);
        rst_n = 1'b1;

        fd0 = fd_count;
        scan_frame(24'h654321, 8);
        scan_frame(24'h654321, 8);
        chk("two_frames_fd", 44'(fd_count - fd0), 44'd2);
        chk("two_frames_digits", 44'(digits), 44'h654321);
        chk("two_frames_valid", 44'(valid), 44'd1);

        fd0 = fd_count;
        scan_digit(0, enc(1, 0), 8);
        scan_digit(1, enc(2, 0), 8);
        scan_digit(2, enc(3, 0), 8);
        scan_digit(3, enc(4, 0), 3);
        scan_digit(4, enc(5, 0), 8);
        scan_digit(5, enc(6, 0), 8);
        chk("short_hold_no_fd", 44'(fd_count - fd0), 44'd0);
        chk("short_hold_seen3", 44'(dut.seen_q[3]), 44'd0);
        scan_digit(3, enc(4, 0), 6);
        chk("rescan_fd", 44'(fd_count - fd0), 44'd1);

        scan_digit(0, enc(1, 0), 8);
        scan_digit(1, enc(2, 0), 8);
        scan_digit(2, 8'hFF, 8);
        scan_digit(3, enc(4, 0), 8);
        scan_digit(4, 8'h00, 8);
        scan_digit(5, 8'h55, 8);
        chk("pattern_blank", 44'(blank), 44'h04);
        chk("pattern_err", 44'(err), 44'h20);
        chk("pattern_dp4", 44'(dp[4]), 44'd1);
        chk("pattern_val4", 44'(digits[19:16]), 44'd8);
        chk("pattern_blank_err_vals", 44'({digits[23:20], digits[11:8]}), 44'd0);

        scan_frame(24'h654323, 8);
        scan_frame(24'h654323, 8);
        chk("stable_a_valid", 44'(valid), 44'd1);
        scan_frame(24'h654327, 8);
        chk("changed_valid_drop", 44'(valid), 44'd0);
        scan_frame(24'h654327, 8);
        chk("changed_valid_back", 44'(valid), 44'd1);

        saw49 = 0; saw50 = 0;
        for (int k = 0; k < 60; k++) begin
            cyc(6'h3F, 8'hFF, 1'b0);
            if (cycle_no - m_last_fd == 49) begin
                chk("timeout_valid_before", 44'(valid), 44'd1);
                saw49 = 1;
            end
            if (cycle_no - m_last_fd == 50) begin
                chk("timeout_valid_drop", 44'(valid), 44'd0);
                chk("timeout_digits_kept", 44'(digits), 44'h654327);
                saw50 = 1;
            end
        end
        chk("timeout_points_reached", 44'({saw49, saw50}), 44'd3);

        fd0 = fd_count;
        scan_digit(0, enc(9, 0), 8);
        scan_digit(1, enc(10, 1), 8);
        scan_digit(2, enc(11, 0), 8);
        for (int k = 0; k < 20; k++) cyc(6'b111100, enc(8, 0), 1'b0);
        chk("two_low_idle", 44'(dut.state_q), 44'(ST_IDLE));
        chk("two_low_seen", 44'(dut.seen_q), 44'h07);
        chk("two_low_no_fd", 44'(fd_count - fd0), 44'd0);
        cyc(6'h3F, 8'hFF, 1'b1);
        chk("clr_outputs", {digits, dp, blank, err, frame_done, valid}, 44'd0);
        chk("clr_seen", 44'(dut.seen_q), 44'd0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 99) < 85) rs = ~(6'(1) << $urandom_range(0, 5));
            else rs = 6'($urandom);
            if ($urandom_range(0, 9) < 7) rd = enc(int'($urandom_range(0, 15)), 1'($urandom));
            else rd = 8'($urandom);
            rl = int'($urandom_range(1, 9));
            rc = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < rl; k++) cyc(rs, rd, (k == 0) ? rc : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
